// File: rtl/data_io_pkg.sv
// Shared definitions for the data_io download path: copier FSM state encoding
// and the UIO file-transfer command bytes understood by data_io.
package data_io_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_HOLD  = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_LAT   = 3'd3;
    localparam state_t ST_WRITE = 3'd4;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
    localparam logic [7:0] UIO_FILE_INFO   = 8'h56;

endpackage

// File: rtl/data_io_copier.sv
// Copies a finished data_io download from its RAM into target memory one byte
// at a time over a req/ack port, holding the console CPU in reset meanwhile.
module data_io_copier
    import data_io_pkg::*;
#(
    parameter int unsigned       RAM_AW    = 15,
    parameter int unsigned       TGT_AW    = 16,
    parameter logic [TGT_AW-1:0] TGT_BASE  = 16'h0000,
    parameter logic [7:0]        INDEX_SEL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dl_downloading,
    input  logic [15:0]       dl_size,
    input  logic [7:0]        dl_index,
    output logic [RAM_AW-1:0] ram_a,
    input  logic [7:0]        ram_dout,
    output logic [TGT_AW-1:0] tgt_addr,
    output logic [7:0]        tgt_data,
    output logic              tgt_req,
    input  logic              tgt_ack,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done_pulse
);

    localparam logic [16:0] RAM_CAP = 17'(1) << RAM_AW;

    state_t              state_q, state_d;
    logic                dl_q;
    logic [15:0]         n_q, n_d;
    logic [15:0]         i_q, i_d;
    logic [RAM_AW-1:0]   ram_a_q, ram_a_d;
    logic [TGT_AW-1:0]   tgt_addr_q, tgt_addr_d;
    logic [7:0]          tgt_data_q, tgt_data_d;
    logic                tgt_req_q, tgt_req_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                dl_rise;
    logic                dl_fall;
    logic [15:0]         size_clamped;
    logic                copying;

    assign dl_rise = dl_downloading & ~dl_q;
    assign dl_fall = ~dl_downloading & dl_q;
    assign copying = (state_q == ST_ADDR) || (state_q == ST_LAT) || (state_q == ST_WRITE);

    // Downloads larger than the RAM only ever hold the first 2^RAM_AW bytes.
    assign size_clamped = ({1'b0, dl_size} > RAM_CAP) ? RAM_CAP[15:0] : dl_size;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        ram_a_d     = ram_a_q;
        tgt_addr_d  = tgt_addr_q;
        tgt_data_d  = tgt_data_q;
        tgt_req_d   = tgt_req_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cpu_reset_d = 1'b0;
                if (dl_rise) begin
                    state_d     = ST_HOLD;
                    cpu_reset_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (dl_fall) begin
                    n_d = size_clamped;
                    i_d = '0;
                    if (size_clamped == 16'd0 || dl_index != INDEX_SEL) begin
                        state_d     = ST_IDLE;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                        ram_a_d = '0;
                    end
                end
            end
            ST_ADDR: begin
                // Address is already presented on entry so the RAM read overlaps ADDR.
                ram_a_d = i_q[RAM_AW-1:0];
                state_d = ST_LAT;
            end
            ST_LAT: begin
                tgt_data_d = ram_dout;
                tgt_addr_d = TGT_BASE + TGT_AW'(i_q);
                tgt_req_d  = 1'b1;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                if (tgt_ack) begin
                    tgt_req_d = 1'b0;
                    i_d       = i_q + 16'd1;
                    if (i_q + 16'd1 == n_q) begin
                        state_d     = ST_IDLE;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                        ram_a_d = i_d[RAM_AW-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new download mid-copy abandons the current one without waiting for ack.
        if (copying && dl_rise) begin
            state_d     = ST_HOLD;
            tgt_req_d   = 1'b0;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
        end

        busy_d = (state_d == ST_ADDR) || (state_d == ST_LAT) || (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dl_q        <= 1'b0;
            n_q         <= '0;
            i_q         <= '0;
            ram_a_q     <= '0;
            tgt_addr_q  <= '0;
            tgt_data_q  <= '0;
            tgt_req_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_downloading;
            n_q         <= n_d;
            i_q         <= i_d;
            ram_a_q     <= ram_a_d;
            tgt_addr_q  <= tgt_addr_d;
            tgt_data_q  <= tgt_data_d;
            tgt_req_q   <= tgt_req_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ram_a      = ram_a_q;
    assign tgt_addr   = tgt_addr_q;
    assign tgt_data   = tgt_data_q;
    assign tgt_req    = tgt_req_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_data_io_copier.sv
// Directed and randomized bench for data_io_copier: a byte-array RAM model and
// expected writes computed from size/index/base arithmetic.
module tb_data_io_copier;

    localparam int unsigned RAW    = 10;
    localparam int unsigned CAP    = 1 << RAW;
    localparam logic [15:0] BASE_B = 16'hFFFE;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           dl_downloading = 1'b0;
    logic [15:0]    dl_size = '0;
    logic [7:0]     dl_index = '0;
    logic           tgt_ack = 1'b0;
    logic [7:0]     ram_dout;
    logic [RAW-1:0] ram_a, ram_a_b;
    logic [15:0]    tgt_addr, tgt_addr_b;
    logic [7:0]     tgt_data, tgt_data_b;
    logic           tgt_req, tgt_req_b;
    logic           cpu_reset, cpu_reset_b;
    logic           busy, busy_b;
    logic           done_pulse, done_pulse_b;

    logic [7:0]     mem [CAP];
    int             tests = 0;
    int             fails = 0;

    always #5 clk = ~clk;

    // Synchronous RAM read port, one cycle of latency.
    always @(posedge clk) ram_dout <= mem[ram_a];

    data_io_copier #(
        .RAM_AW    (RAW),
        .TGT_AW    (16),
        .TGT_BASE  (16'h0000),
        .INDEX_SEL (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dl_downloading (dl_downloading),
        .dl_size        (dl_size),
        .dl_index       (dl_index),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .tgt_addr       (tgt_addr),
        .tgt_data       (tgt_data),
        .tgt_req        (tgt_req),
        .tgt_ack        (tgt_ack),
        .cpu_reset      (cpu_reset),
        .busy           (busy),
        .done_pulse     (done_pulse)
    );

    // Same stimulus, base near the top of the target space to exercise wrap.
    data_io_copier #(
        .RAM_AW    (RAW),
        .TGT_AW    (16),
        .TGT_BASE  (BASE_B),
        .INDEX_SEL (8'h00)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .dl_downloading (dl_downloading),
        .dl_size        (dl_size),
        .dl_index       (dl_index),
        .ram_a          (ram_a_b),
        .ram_dout       (ram_dout),
        .tgt_addr       (tgt_addr_b),
        .tgt_data       (tgt_data_b),
        .tgt_req        (tgt_req_b),
        .tgt_ack        (tgt_ack),
        .cpu_reset      (cpu_reset_b),
        .busy           (busy_b),
        .done_pulse     (done_pulse_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rise_dl();
        dl_downloading = 1'b1;
        tick();
        check("rise_cpu_reset", cpu_reset, 1);
        check("rise_cpu_reset_b", cpu_reset_b, 1);
        check("rise_busy", busy, 0);
        tick();
        check("hold_cpu_reset", cpu_reset, 1);
    endtask

    // Drop dl_downloading and act as the target, checking every expected write.
    task automatic fall_and_serve(input logic [15:0] size, input logic [7:0] idx,
                                  input int delay, input int abort_at);
        int n;
        int waited;
        int writes;
        bit copy;
        n      = (int'(size) > CAP) ? CAP : int'(size);
        copy   = (n != 0) && (idx == 8'h00);
        writes = 0;
        dl_size        = size;
        dl_index       = idx;
        dl_downloading = 1'b0;
        if (!copy) begin
            tick();
            check("skip_done", done_pulse, 1);
            check("skip_cpu_reset", cpu_reset, 0);
            check("skip_req", tgt_req, 0);
            check("skip_busy", busy, 0);
            tick();
            check("skip_done_clear", done_pulse, 0);
            check("skip_req_after", tgt_req, 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (tgt_req !== 1'b1 && waited < 8);
            check("req_seen", tgt_req, 1);
            if (tgt_req !== 1'b1) return;
            check("req_latency", waited, (k == 0) ? 3 : 2);
            check("addr", tgt_addr, 32'(16'(k)));
            check("addr_b", tgt_addr_b, 32'(16'(BASE_B + 16'(k))));
            check("data", tgt_data, mem[k]);
            check("data_b", tgt_data_b, mem[k]);
            check("ram_a", ram_a, k % CAP);
            check("ram_a_b", ram_a_b, k % CAP);
            check("req_b", tgt_req_b, 1);
            check("cpu_reset_copy", cpu_reset, 1);
            check("busy_copy", busy, 1);
            if (k == abort_at) begin
                dl_downloading = 1'b1;
                tick();
                check("abort_req", tgt_req, 0);
                check("abort_busy", busy, 0);
                check("abort_cpu_reset", cpu_reset, 1);
                check("abort_done", done_pulse, 0);
                return;
            end
            for (int d = 0; d < delay; d++) begin
                tick();
                check("req_hold", tgt_req, 1);
                check("addr_hold", tgt_addr, 32'(16'(k)));
                check("data_hold", tgt_data, mem[k]);
            end
            tgt_ack = 1'b1;
            tick();
            tgt_ack = 1'b0;
            writes++;
            check("req_drop", tgt_req, 0);
            check("done", done_pulse, (k == n - 1) ? 1 : 0);
            check("done_b", done_pulse_b, (k == n - 1) ? 1 : 0);
            check("cpu_reset_end", cpu_reset, (k == n - 1) ? 0 : 1);
            check("cpu_reset_end_b", cpu_reset_b, (k == n - 1) ? 0 : 1);
            check("busy_after_ack", busy, (k == n - 1) ? 0 : 1);
            check("busy_after_ack_b", busy_b, (k == n - 1) ? 0 : 1);
        end
        check("write_count", writes, n);
        tick();
        check("done_clear", done_pulse, 0);
        check("idle_req", tgt_req, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < CAP; j++) mem[j] = 8'($urandom);

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_req", tgt_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_pulse, 0);
        check("rst_ram_a", ram_a, 0);
        check("rst_tgt_addr", tgt_addr, 0);
        check("rst_tgt_data", tgt_data, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_cpu_reset", cpu_reset, 0);
        check("post_rst_busy", busy, 0);

        // Four known bytes, ack two cycles after each request.
        mem[0] = 8'hA1;
        mem[1] = 8'hB2;
        mem[2] = 8'hC3;
        mem[3] = 8'hD4;
        rise_dl();
        fall_and_serve(16'd4, 8'h00, 2, -1);

        rise_dl();
        fall_and_serve(16'd0, 8'h00, 0, -1);

        rise_dl();
        fall_and_serve(16'd5, 8'h03, 1, -1);

        // Ack with no request outstanding must do nothing.
        tgt_ack = 1'b1;
        tick();
        tgt_ack = 1'b0;
        tick();
        check("stray_ack_req", tgt_req, 0);
        check("stray_ack_busy", busy, 0);
        check("stray_ack_done", done_pulse, 0);

        for (int t = 0; t < 8; t++) begin
            for (int j = 0; j < 32; j++) mem[j] = 8'($urandom);
            rise_dl();
            fall_and_serve(16'($urandom_range(1, 24)),
                           ($urandom_range(0, 3) == 0) ? 8'h07 : 8'h00,
                           int'($urandom_range(0, 3)), -1);
        end

        // Oversized download is clamped to the RAM capacity.
        for (int j = 0; j < CAP; j++) mem[j] = 8'($urandom);
        rise_dl();
        fall_and_serve(16'h0900, 8'h00, 0, -1);

        // Abort while waiting for ack on byte 2, then a full restart from byte 0.
        rise_dl();
        fall_and_serve(16'd6, 8'h00, 1, 2);
        for (int j = 0; j < 8; j++) mem[j] = 8'($urandom);
        tick();
        check("abort_hold_cpu_reset", cpu_reset, 1);
        tick();
        fall_and_serve(16'd6, 8'h00, 1, -1);

        // Reset in the middle of a write drops the request without a clock edge.
        rise_dl();
        dl_size        = 16'd4;
        dl_index       = 8'h00;
        dl_downloading = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_req", tgt_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", tgt_req, 0);
        check("async_rst_cpu_reset", cpu_reset, 1);
        check("async_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rerst_cpu_reset", cpu_reset, 0);

        mem[0] = 8'h5A;
        mem[1] = 8'hA5;
        rise_dl();
        fall_and_serve(16'd2, 8'h00, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
